// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- decode-stage immediate generator with a 2-entry skid buffer.
//
// Pulls the immediate for every RV64I format (I/S/B/U/J) plus CSR zimm and
// shift amount straight out of the raw instruction word. The result sits in
// a main register (M) that drives the outputs. A skid register (K) catches
// the one extra entry that can arrive while M is stalled. Because of K,
// ready_o is a flop and never depends on ready_i in the same cycle.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   flush_i               synchronous flush: drops M, K and any same-edge input
//   valid_i/ready_o       input handshake
//   inst_i, immsel_i      raw instruction, format select (0..6 legal, 7 illegal)
//   tag_i                 sideband tag carried with the immediate
//   valid_o/ready_i       output handshake
//   imm_o, tag_o, err_o   extended immediate, its tag, illegal-select flag
//   err_cnt_o             saturating illegal-select count
//
// Build option:
//   IMM_GEN_ERR_CNT_EN    when defined, err_cnt_o is a 16-bit saturating count
//                         of accepted, non-flushed immsel=7 inputs. When left
//                         undefined, err_cnt_o is tied to 0 and no counter
//                         exists.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [ILEN-1:0]  inst_i,
  input  logic [2:0]       immsel_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o,
  output logic [15:0]      err_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  ent_t        in_ent, m_q, m_d, k_q, k_d;
  logic        m_vld_q, m_vld_d, k_vld_q, k_vld_d, rdy_q, rdy_d;
  logic        acc, cons;
  logic [31:0] sx, zx;
  logic        use_z;
  logic [63:0] imm64;

  // The opcode field plays no part in immediate formation.
  logic unused_opcode;
  assign unused_opcode = ^inst_i[6:0];

  // Every format fits in 32 bits first. It is then sign- or zero-extended to
  // 64 bits and cut down to XLEN.
  always_comb begin
    sx           = '0;
    zx           = '0;
    use_z        = 1'b0;
    in_ent.err   = 1'b0;
    case (immsel_i)
      3'd0: sx = {{20{inst_i[31]}}, inst_i[31:20]};
      3'd1: sx = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      3'd2: sx = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
      3'd3: sx = {inst_i[31:12], 12'b0};
      3'd4: sx = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};
      3'd5: begin use_z = 1'b1; zx = {27'b0, inst_i[19:15]}; end
      3'd6: begin
        use_z = 1'b1;
        zx    = (XLEN == 32) ? {27'b0, inst_i[24:20]} : {26'b0, inst_i[25:20]};
      end
      default: in_ent.err = 1'b1;
    endcase
    imm64      = use_z ? {32'b0, zx} : {{32{sx[31]}}, sx};
    in_ent.imm = imm64[XLEN-1:0];
    in_ent.tag = tag_i;
  end

  assign acc  = valid_i & rdy_q;
  assign cons = m_vld_q & ready_i;

  // Skid-buffer next state. If K is full then ready_o is 0, so acc is 0 in
  // that case. This means K->M and input->M never happen on the same edge.
  always_comb begin
    m_d     = m_q;
    k_d     = k_q;
    m_vld_d = m_vld_q;
    k_vld_d = k_vld_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end else if (!m_vld_q || cons) begin
      if (k_vld_q) begin
        m_d     = k_q;
        m_vld_d = 1'b1;
        k_vld_d = 1'b0;
      end else begin
        m_vld_d = acc;
        if (acc) m_d = in_ent;
      end
    end else if (acc) begin
      k_d     = in_ent;
      k_vld_d = 1'b1;
    end
    rdy_d = ~k_vld_d;
  end

  // rdy_q resets low, so ready_o first rises on the edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      k_q     <= '0;
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      m_q     <= m_d;
      k_q     <= k_d;
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ready_o = rdy_q;
  assign valid_o = m_vld_q;
  assign imm_o   = m_q.imm;
  assign tag_o   = m_q.tag;
  assign err_o   = m_q.err;

`ifdef IMM_GEN_ERR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && !flush_i && in_ent.err && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Only rst clears the count; flush_i leaves it as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 8;
`ifdef IMM_GEN_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk, rst, flush_i, valid_i, ready_o, valid_o, ready_i, err_o;
  logic [31:0]      inst_i;
  logic [2:0]       immsel_i;
  logic [TAG_W-1:0] tag_i, tag_o;
  logic [XLEN-1:0]  imm_o;
  logic [15:0]      err_cnt_o;

  imm_gen_pipe #(.XLEN(XLEN), .ILEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .immsel_i(immsel_i), .tag_i(tag_i), .valid_o(valid_o),
    .ready_i(ready_i), .imm_o(imm_o), .tag_o(tag_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   err_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model. Each immediate is built from the sign-extended
  // instruction with plain shifts, following the field layout of each format.
  function automatic exp_t model(input logic [31:0] in, input logic [2:0] sel,
                                 input logic [7:0] tg);
    exp_t   e;
    longint s, r;
    s = longint'($signed(in));
    r = 0;
    e.err = 1'b0;
    case (sel)
      3'd0: r = s >>> 20;
      3'd1: r = ((s >>> 25) <<< 5) | longint'(in[11:7]);
      3'd2: r = ((s >>> 31) <<< 12) | (longint'(in[7]) << 11) |
                (longint'(in[30:25]) << 5) | (longint'(in[11:8]) << 1);
      3'd3: r = (s >>> 12) <<< 12;
      3'd4: r = ((s >>> 31) <<< 20) | (longint'(in[19:12]) << 12) |
                (longint'(in[20]) << 11) | (longint'(in[30:21]) << 1);
      3'd5: r = longint'(in[19:15]);
      3'd6: r = longint'(in[25:20]);
      default: e.err = 1'b1;
    endcase
    e.imm = r;
    e.tag = tg;
    return e;
  endfunction

  // Input side: at each negedge, look at what the next posedge will see and
  // push the expected entry for each accepted input.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      err_exp = 0;
    end else begin
      chk("err_cnt", {48'b0, err_cnt_o}, CNT_EN ? 64'(err_exp) : 64'd0);
      if (flush_i) sbq.delete();
      else if (valid_i && ready_o) begin
        sbq.push_back(model(inst_i, immsel_i, tag_i));
        if (immsel_i == 3'd7 && err_exp < 65535) err_exp++;
      end
    end
  end

  // Output side: pop and compare on each consumed output. Also check that a
  // stalled output holds steady.
  exp_t prev;
  bit   have_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) have_prev = 1'b0;
    else begin
      if (have_prev) begin
        chk("hold_valid", {63'b0, valid_o}, 64'd1);
        chk("hold_imm", imm_o, prev.imm);
        chk("hold_tag", {56'b0, tag_o}, {56'b0, prev.tag});
      end
      have_prev = 1'b0;
      if (valid_o && !flush_i) begin
        if (ready_i) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL spurious_out: got tag %h want none", tag_o);
          end else begin
            total--;
            e = sbq.pop_front();
            chk("sb_imm", imm_o, e.imm);
            chk("sb_tag", {56'b0, tag_o}, {56'b0, e.tag});
            chk("sb_err", {63'b0, err_o}, {63'b0, e.err});
          end
        end else begin
          have_prev = 1'b1;
          prev.imm  = imm_o;
          prev.tag  = tag_o;
          prev.err  = err_o;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chk(input string name, input logic [31:0] ins, input logic [2:0] sel,
                          input logic [7:0] tg, input logic [63:0] exp_imm, input logic exp_err);
    valid_i = 1'b1; inst_i = ins; immsel_i = sel; tag_i = tg;
    step();
    valid_i = 1'b0;
    chk({name, "_valid"}, {63'b0, valid_o}, 64'd1);
    chk({name, "_imm"}, imm_o, exp_imm);
    chk({name, "_tag"}, {56'b0, tag_o}, {56'b0, tg});
    chk({name, "_err"}, {63'b0, err_o}, {63'b0, exp_err});
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    inst_i = '0; immsel_i = '0; tag_i = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", {63'b0, valid_o}, 64'd0);
    chk("rst_imm", imm_o, 64'd0);
    chk("rst_tag", {56'b0, tag_o}, 64'd0);
    chk("rst_err", {63'b0, err_o}, 64'd0);
    chk("rst_cnt", {48'b0, err_cnt_o}, 64'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", {63'b0, ready_o}, 64'd1);

    // Directed format checks with the consumer always ready
    ready_i = 1'b1;
    send_chk("addi", 32'hFFF00093, 3'd0, 8'h11, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send_chk("sw",   32'hFE112E23, 3'd1, 8'h12, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_chk("beq",  32'hFE000EE3, 3'd2, 8'h13, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_chk("lui",  32'h800000B7, 3'd3, 8'h14, 64'hFFFFFFFF80000000, 1'b0);
    send_chk("jal",  32'hFFDFF06F, 3'd4, 8'h15, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send_chk("zimm", 32'h800F8073, 3'd5, 8'h16, 64'h000000000000001F, 1'b0);
    send_chk("shamt", 32'h83F01013, 3'd6, 8'h17, 64'h000000000000003F, 1'b0);
    step();

    // Backpressure: tags 1, 2, 3 back to back while the consumer stalls
    ready_i = 1'b0; valid_i = 1'b1; inst_i = 32'h00100093; immsel_i = 3'd0;
    tag_i = 8'd1; step();
    tag_i = 8'd2; step();
    chk("bp_ready_low", {63'b0, ready_o}, 64'd0);
    chk("bp_m_tag", {56'b0, tag_o}, 64'd1);
    tag_i = 8'd3; step(); step();
    chk("bp_still_low", {63'b0, ready_o}, 64'd0);
    chk("bp_held_tag", {56'b0, tag_o}, 64'd1);
    ready_i = 1'b1; step();
    chk("bp_tag2", {56'b0, tag_o}, 64'd2);
    chk("bp_ready_up", {63'b0, ready_o}, 64'd1);
    step();
    valid_i = 1'b0;
    chk("bp_tag3", {56'b0, tag_o}, 64'd3);
    step();
    chk("bp_drained", {63'b0, valid_o}, 64'd0);

    // Flush while M and K are full, with an illegal input on the same edge
    ready_i = 1'b0; valid_i = 1'b1; immsel_i = 3'd0;
    tag_i = 8'h21; step();
    tag_i = 8'h22; step();
    flush_i = 1'b1; immsel_i = 3'd7; tag_i = 8'h23; step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_valid", {63'b0, valid_o}, 64'd0);
    chk("flush_ready", {63'b0, ready_o}, 64'd1);
    chk("flush_cnt", {48'b0, err_cnt_o}, 64'd0);
    ready_i = 1'b1;
    send_chk("ill1", 32'hDEADBEEF, 3'd7, 8'h31, 64'd0, 1'b1);
    send_chk("ill2", 32'h12345678, 3'd7, 8'h32, 64'd0, 1'b1);
    chk("ill_cnt", {48'b0, err_cnt_o}, CNT_EN ? 64'd2 : 64'd0);
    step();

    // Randomized traffic, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      valid_i  = ($urandom_range(0, 3) != 0);
      inst_i   = $urandom;
      immsel_i = 3'($urandom_range(0, 7));
      tag_i    = 8'($urandom);
      ready_i  = ($urandom_range(0, 3) != 0);
      flush_i  = ($urandom_range(0, 31) == 0);
      step();
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (5) step();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    // Reset in the middle of a stalled transfer
    ready_i = 1'b0; valid_i = 1'b1; inst_i = 32'hFFF00093; immsel_i = 3'd7; tag_i = 8'h55;
    step(); step();
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'b0, valid_o}, 64'd0);
    chk("mid_rst_imm", imm_o, 64'd0);
    chk("mid_rst_tag", {56'b0, tag_o}, 64'd0);
    chk("mid_rst_err", {63'b0, err_o}, 64'd0);
    chk("mid_rst_cnt", {48'b0, err_cnt_o}, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_ready", {63'b0, ready_o}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
